// File: rtl/demux_pkg.sv
// Shared constants, select type and the one-hot helper for the 1-to-4 demux.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot of sel when en is high, all-zero otherwise.
  function automatic logic [NUM_OUT-1:0] onehot4(input sel_t sel, input logic en);
    logic [NUM_OUT-1:0] r;
    r = '0;
    if (en) begin
      r = 4'b0001 << sel;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_decode_core.sv
// Combinational decode core: gate-level, dataflow and behavioural decoders plus
// a disagreement flag. With CHECK_EN=0 only the behavioural decoder exists.
module demux_decode_core
  import demux_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               a_i,
  input  logic               b_i,
  input  logic               en_i,
  output logic [NUM_OUT-1:0] zc_o,
  output logic               mismatch_c_o
);

  sel_t               sel;
  logic [NUM_OUT-1:0] zc_beh;

  assign sel = {b_i, a_i};

  always_comb begin
    zc_beh = '0;
    case (sel)
      2'd0:    zc_beh[0] = en_i;
      2'd1:    zc_beh[1] = en_i;
      2'd2:    zc_beh[2] = en_i;
      2'd3:    zc_beh[3] = en_i;
      default: zc_beh = '0;
    endcase
  end

  assign zc_o = zc_beh;

  generate
    if (CHECK_EN) begin : g_check
      wire                na;
      wire                nb;
      wire [NUM_OUT-1:0]  zc_gate;
      logic [NUM_OUT-1:0] zc_df;

      not g_na (na, a_i);
      not g_nb (nb, b_i);
      and g_z0 (zc_gate[0], nb,  na,  en_i);
      and g_z1 (zc_gate[1], nb,  a_i, en_i);
      and g_z2 (zc_gate[2], b_i, na,  en_i);
      and g_z3 (zc_gate[3], b_i, a_i, en_i);

      assign zc_df = onehot4(sel, en_i);

      assign mismatch_c_o = (zc_gate != zc_df) | (zc_df != zc_beh);
    end else begin : g_nocheck
      assign mismatch_c_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: routes en to z[{b,a}] one cycle later and
// flags any disagreement between the internal decoders.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a,
  input  logic               b,
  input  logic               en,
  output logic [NUM_OUT-1:0] z,
  output logic               mismatch
);

  logic [NUM_OUT-1:0] zc;
  logic               mismatch_c;
  logic [NUM_OUT-1:0] z_d, z_q;
  logic               mismatch_d, mismatch_q;

  demux_decode_core #(
    .CHECK_EN (CHECK_EN)
  ) u_core (
    .a_i          (a),
    .b_i          (b),
    .en_i         (en),
    .zc_o         (zc),
    .mismatch_c_o (mismatch_c)
  );

  assign z_d        = zc;
  assign mismatch_d = mismatch_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q        <= '0;
      mismatch_q <= 1'b0;
    end else begin
      z_q        <= z_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign z        = z_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: table vectors, reset/latency sequences and random
// stimulus against a reference model, on both CHECK_EN builds in lockstep.
module tb_demux_1to4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, en;
  logic [3:0] z, z_nc;
  logic       mismatch, mismatch_nc;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       b;
    logic       a;
    logic       en;
    logic [3:0] exp_z;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  demux_1to4_reg #(.CHECK_EN(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .a (a), .b (b), .en (en),
    .z (z), .mismatch (mismatch)
  );

  demux_1to4_reg #(.CHECK_EN(1'b0)) dut_nc (
    .clk (clk), .rst_n (rst_n), .a (a), .b (b), .en (en),
    .z (z_nc), .mismatch (mismatch_nc)
  );

  // Output i is high exactly when enabled and i equals the numeric select b*2+a.
  function automatic logic [3:0] model_z(input logic mb, input logic ma, input logic men);
    logic [3:0] r;
    int idx;
    idx = (mb ? 2 : 0) + (ma ? 1 : 0);
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = men && (i == idx);
    end
    return r;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] exp);
    check4({name, "_z"}, z, exp);
    check1({name, "_mismatch"}, mismatch, 1'b0);
    check4({name, "_z_nc"}, z_nc, exp);
    check1({name, "_mismatch_nc"}, mismatch_nc, 1'b0);
    check1({name, "_onehot"}, ($countones(z) <= 1), 1'b1);
  endtask

  task automatic step(input string name, input logic sb, input logic sa, input logic sen);
    logic [3:0] e;
    @(negedge clk);
    b  = sb;
    a  = sa;
    en = sen;
    exp_q.push_back(model_z(sb, sa, sen));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outs(name, e);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b0001};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'b0010};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'b0000};

    // Reset held with a live select: outputs stay cleared across edges.
    rst_n = 1'b0;
    b = 1'b1; a = 1'b1; en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_outs("rst_hold", 4'b0000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rst_release", 4'b1000);

    // Sweep and enable-off vectors.
    for (int i = 0; i < 12; i++) begin
      step("tbl_model", tbl[i].b, tbl[i].a, tbl[i].en);
      check4("tbl_const", z, tbl[i].exp_z);
    end

    // Select change mid-cycle is invisible until the next edge.
    step("lat_pre", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    b = 1'b1; a = 1'b1;
    #1;
    check4("lat_hold", z, 4'b0001);
    @(posedge clk);
    #1;
    check_outs("lat_after", 4'b1000);

    // Asynchronous reset between edges.
    step("async_pre", 1'b1, 1'b0, 1'b1);
    check4("async_pre_const", z, 4'b0100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_assert", 4'b0000);
    #1;
    rst_n = 1'b1;
    check_outs("async_release_noedge", 4'b0000);
    @(posedge clk);
    #1;
    check_outs("async_resume", 4'b0100);

    // Random stimulus against the model on both builds.
    for (int i = 0; i < 1000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
